rv32_mod_stage_sequencer: RTL and testbench
===========================================

# rv32_mod_stage_sequencer

Multi-cycle control FSM for the rv32imc_ss core. It fetches an instruction over the instruction bus and latches it into the instruction register that feeds `rv32_mod_instruction_decoder`. It then steps the decoded instruction through decode, execute, optional memory access and writeback, and owns the PC register, bus handshakes, bus timeout and trap state.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `TIMEOUT`, 16, maximum cycles a bus request may wait for ack/err; 0 disables the timeout
- `clk`  in  1  core clock
- `rstn`  in  1  reset, asynchronous, active-low
- `halt_req`  in  1  request to stop after the current instruction retires
- `ibus_req`  out  1  instruction fetch request
- `ibus_addr`  out  32  fetch address, equal to `pc`
- `ibus_ack`  in  1  fetch complete; `ibus_rdata` is valid
- `ibus_err`  in  1  fetch bus error
- `ibus_rdata`  in  32  fetched word
- `instruction`  out  32  instruction register, drives the decoder `instruction` input
- `dec_is_mem_or_io`  in  1  from the decoder
- `dec_is_compressed`  in  1  from the decoder
- `exec_en`  out  1  one-cycle strobe: ALU/branch unit captures its result
- `dbus_req`  out  1  load/store request
- `dbus_ack`  in  1  load/store complete
- `dbus_err`  in  1  load/store bus error
- `rf_we`  out  1  one-cycle register-file write strobe
- `next_pc`  in  32  PC from the branch unit, valid in WRITEBACK
- `pc`  out  32  current PC
- `pc_step`  out  3  sequential increment: 4, or 2 for compressed instructions
- `retired`  out  1  one-cycle pulse per retired instruction
- `state`  out  3  encoded FSM state, for debug
- `trap`  out  1  sticky fault flag
- `trap_cause`  out  2  0 = none, 1 = bus error, 2 = illegal/compressed, 3 = timeout

## Operation
- State encodings: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, HALT=5, TRAP=6.
- FETCH
  - `ibus_req`=1 is held until `ibus_ack` or `ibus_err`.
  - On ack: `instruction` <= `ibus_rdata`, go to DECODE.
  - On err: go to TRAP with cause 1.
- DECODE (1 cycle)
  - Decoder outputs are combinational off `instruction`.
  - If `dec_is_compressed` and `RV32_SEQ_COMPRESSED_EN` is undefined: go to TRAP with cause 2.
  - Otherwise go to EXECUTE.
- EXECUTE (1 cycle)
  - `exec_en`=1.
  - If `dec_is_mem_or_io`: go to MEM; otherwise go to WRITEBACK.
- MEM
  - `dbus_req`=1 is held until `dbus_ack` or `dbus_err`.
  - On ack: go to WRITEBACK. On err: go to TRAP with cause 1.
- WRITEBACK (1 cycle)
  - `rf_we`=1, `retired`=1, `pc` <= `next_pc`.
  - If `halt_req`: go to HALT; otherwise go to FETCH.
- HALT
  - No bus requests.
  - When `halt_req`=0: go to FETCH using the current `pc`.
- TRAP
  - Absorbing state. `trap`=1, `trap_cause` holds its value.
  - All strobes and requests are 0. Only reset exits TRAP.
- Timeout
  - An 8-bit wait counter clears on entry to FETCH or MEM and increments each cycle `*_req` is high without ack/err.
  - When the counter equals `TIMEOUT`-1 with no ack/err: go to TRAP with cause 3.
  - With `TIMEOUT`=0 the counter is inert.
- Bus inputs
  - `*_ack`/`*_err` are ignored when the matching `*_req` is low.
  - Simultaneous ack and err: err wins.
  - Ack on the timeout-terminal cycle: ack wins.
- PC arithmetic
  - `pc_step` = `dec_is_compressed` ? 3'd2 : 3'd4.
  - The branch unit computes `next_pc` modulo 2^32. `pc` wraps from 32'hFFFF_FFFC to 0 without a fault.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state=FETCH, `pc`=`RESET_PC`, `instruction`=32'h0000_0013 (NOP).
  - `trap`=0, `trap_cause`=0, counter=0.
  - All strobes/requests=0, except `ibus_req`, which is 1 from the first cycle after release.
  - `pc_step` reflects the NOP: 4.
- Asserting reset mid-transaction drops `*_req` immediately. No write or retire occurs.
- Non-memory instruction with single-cycle ack: 4 cycles from `ibus_req` rise to the next `ibus_req` rise. `retired` pulses in cycle 4.
- Memory instruction: 5 + (dbus wait cycles) cycles.
- `exec_en`, `rf_we`, `retired`: exactly one cycle each per instruction, never overlapping.
- `halt_req` is sampled only in WRITEBACK. Leaving HALT costs 0 extra cycles: FETCH follows directly.
- All outputs are registered or decoded from the state register only. There is no combinational path from bus inputs to bus outputs.

## Configuration
- `RV32_SEQ_COMPRESSED_EN` defined: compressed instructions proceed normally and `pc_step`=2 for them.
- `RV32_SEQ_COMPRESSED_EN` undefined: any instruction with `dec_is_compressed`=1 traps in DECODE with `trap_cause`=2.

## Test plan
- Reset release, ack every fetch at once, ADDI stream, `next_pc`=`pc`+4 → `retired` every 4 cycles; `ibus_addr` 0x0, 0x4, 0x8.
- LW with `dbus_ack` delayed 3 cycles → `dbus_req` high 4 cycles, `rf_we` one cycle after ack, 8-cycle instruction.
- `ibus_err` and `ibus_ack` together in FETCH → TRAP, `trap_cause`=1, no `rf_we`; state stays 6 until `rstn` low.
- `TIMEOUT`=4, `dbus_ack` never asserted → TRAP with cause 3 exactly 4 cycles after `dbus_req` rise.
- `halt_req`=1 during EXECUTE → WRITEBACK retires, HALT holds while `halt_req`=1; release → `ibus_req` next cycle at `next_pc`.
- Instruction 0x0001 (compressed): without macro → `trap_cause`=2; with macro → retires, `pc_step`=2.

Source files
------------

// File: rtl/rv32_mod_stage_sequencer.sv
// rv32_mod_stage_sequencer: multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK
// control for rv32imc_ss. Owns the PC, instruction register, bus handshakes,
// bus-wait timeout and the sticky trap state.
// Optional feature macro: RV32_SEQ_COMPRESSED_EN (defined = compressed
// instructions execute; undefined = they trap in DECODE with cause 2).
module rv32_mod_stage_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        halt_req,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_ack,
  input  logic        ibus_err,
  input  logic [31:0] ibus_rdata,
  output logic [31:0] instruction,
  input  logic        dec_is_mem_or_io,
  input  logic        dec_is_compressed,
  output logic        exec_en,
  output logic        dbus_req,
  input  logic        dbus_ack,
  input  logic        dbus_err,
  output logic        rf_we,
  input  logic [31:0] next_pc,
  output logic [31:0] pc,
  output logic [2:0]  pc_step,
  output logic        retired,
  output logic [2:0]  state,
  output logic        trap,
  output logic [1:0]  trap_cause
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5,
    S_TRAP      = 3'd6
  } state_e;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam bit          TO_EN   = (TIMEOUT != 0);
  localparam logic [7:0]  TO_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  cause_q, cause_d;
  logic        trap_q;
  logic        ibus_req_q, dbus_req_q, exec_en_q, rf_we_q, retired_q;
  logic        to_hit;

  assign to_hit = TO_EN && (cnt_q == TO_LAST);

  // Next-state, PC, instruction register and wait-counter logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    unique case (state_q)
      S_FETCH: begin
        if (ibus_req_q) begin
          if (ibus_err) begin
            state_d = S_TRAP;
            cause_d = 2'd1;
          end else if (ibus_ack) begin
            instr_d = ibus_rdata;
            state_d = S_DECODE;
          end else if (to_hit) begin
            state_d = S_TRAP;
            cause_d = 2'd3;
          end else if (TO_EN) begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_DECODE: begin
`ifdef RV32_SEQ_COMPRESSED_EN
        state_d = S_EXECUTE;
`else
        if (dec_is_compressed) begin
          state_d = S_TRAP;
          cause_d = 2'd2;
        end else begin
          state_d = S_EXECUTE;
        end
`endif
      end
      S_EXECUTE: begin
        state_d = dec_is_mem_or_io ? S_MEM : S_WRITEBACK;
      end
      S_MEM: begin
        if (dbus_req_q) begin
          if (dbus_err) begin
            state_d = S_TRAP;
            cause_d = 2'd1;
          end else if (dbus_ack) begin
            state_d = S_WRITEBACK;
          end else if (to_hit) begin
            state_d = S_TRAP;
            cause_d = 2'd3;
          end else if (TO_EN) begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_WRITEBACK: begin
        pc_d    = next_pc;
        state_d = halt_req ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        if (!halt_req) state_d = S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_TRAP;
      end
    endcase
    if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM)))
      cnt_d = '0;
  end

  // State and registered outputs; requests and strobes are decoded from the
  // next state so they are valid in the state they belong to with no path
  // from bus inputs to bus outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= NOP;
      cnt_q      <= '0;
      cause_q    <= '0;
      trap_q     <= 1'b0;
      ibus_req_q <= 1'b0;
      dbus_req_q <= 1'b0;
      exec_en_q  <= 1'b0;
      rf_we_q    <= 1'b0;
      retired_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      cnt_q      <= cnt_d;
      cause_q    <= cause_d;
      trap_q     <= (state_d == S_TRAP);
      ibus_req_q <= (state_d == S_FETCH);
      dbus_req_q <= (state_d == S_MEM);
      exec_en_q  <= (state_d == S_EXECUTE);
      rf_we_q    <= (state_d == S_WRITEBACK);
      retired_q  <= (state_d == S_WRITEBACK);
    end
  end

  assign ibus_req    = ibus_req_q;
  assign ibus_addr   = pc_q;
  assign instruction = instr_q;
  assign exec_en     = exec_en_q;
  assign dbus_req    = dbus_req_q;
  assign rf_we       = rf_we_q;
  assign retired     = retired_q;
  assign pc          = pc_q;
  assign pc_step     = dec_is_compressed ? 3'd2 : 3'd4;
  assign state       = state_q;
  assign trap        = trap_q;
  assign trap_cause  = cause_q;

endmodule

// File: tb/tb_rv32_mod_stage_sequencer.sv
// Scoreboard bench for rv32_mod_stage_sequencer: the stimulus pushes expected
// events (fetch address, dbus hold length, retire info, trap cause) and a
// negedge monitor pops and compares whenever the DUT presents one.
module tb_rv32_mod_stage_sequencer;

  localparam int TO = 4;
  localparam logic [1:0] K_FETCH = 2'd0, K_DBUS = 2'd1, K_RET = 2'd2, K_TRAP = 2'd3;

  logic        clk = 1'b0;
  logic        rstn;
  logic        halt_req;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_ack, ibus_err;
  logic [31:0] ibus_rdata;
  logic [31:0] instruction;
  logic        dec_is_mem_or_io, dec_is_compressed;
  logic        exec_en, dbus_req, dbus_ack, dbus_err, rf_we;
  logic [31:0] next_pc, pc;
  logic [2:0]  pc_step;
  logic        retired;
  logic [2:0]  state;
  logic        trap;
  logic [1:0]  trap_cause;

  always #5 clk = ~clk;

  rv32_mod_stage_sequencer #(
    .RESET_PC (32'h0000_0000),
    .TIMEOUT  (TO)
  ) dut (
    .clk               (clk),
    .rstn              (rstn),
    .halt_req          (halt_req),
    .ibus_req          (ibus_req),
    .ibus_addr         (ibus_addr),
    .ibus_ack          (ibus_ack),
    .ibus_err          (ibus_err),
    .ibus_rdata        (ibus_rdata),
    .instruction       (instruction),
    .dec_is_mem_or_io  (dec_is_mem_or_io),
    .dec_is_compressed (dec_is_compressed),
    .exec_en           (exec_en),
    .dbus_req          (dbus_req),
    .dbus_ack          (dbus_ack),
    .dbus_err          (dbus_err),
    .rf_we             (rf_we),
    .next_pc           (next_pc),
    .pc                (pc),
    .pc_step           (pc_step),
    .retired           (retired),
    .state             (state),
    .trap              (trap),
    .trap_cause        (trap_cause)
  );

  typedef struct packed {
    logic [1:0]  kind;
    logic [63:0] data;
  } ev_t;

  ev_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc;

  function automatic string kname(input logic [1:0] k);
    case (k)
      K_FETCH: return "fetch";
      K_DBUS:  return "dbus_hold";
      K_RET:   return "retire";
      default: return "trap";
    endcase
  endfunction

  // retire record: {cycle index since fetch rise, exec_en pulses, rf_we, 0, pc}
  function automatic logic [63:0] ret_data(input int lat, input logic [31:0] a);
    return {8'(lat), 8'd1, 8'd1, 8'd0, a};
  endfunction

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push(input logic [1:0] k, input logic [63:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic observe(input logic [1:0] k, input logic [63:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_%s actual=%h required=none", kname(k), d);
    end else begin
      e = exp_q.pop_front();
      check({"ev_", kname(e.kind)}, {k, d}, {e.kind, e.data});
    end
  endtask

  // Monitor
  logic prev_ireq, prev_dreq, prev_trap;
  int   since, dcnt, nexec;

  always @(negedge clk) begin
    if (!rstn) begin
      prev_ireq = 1'b0;
      prev_dreq = 1'b0;
      prev_trap = 1'b0;
      since     = 0;
      dcnt      = 0;
      nexec     = 0;
    end else begin
      if (ibus_req && !prev_ireq) begin
        since = 1;
        nexec = 0;
        observe(K_FETCH, {32'd0, ibus_addr});
      end else begin
        since++;
      end
      if (exec_en) nexec++;
      if (dbus_req) dcnt++;
      else if (prev_dreq) begin
        observe(K_DBUS, 64'(dcnt));
        dcnt = 0;
      end
      if (retired) observe(K_RET, {8'(since), 8'(nexec), 7'd0, rf_we, 8'd0, pc});
      if (trap && !prev_trap) observe(K_TRAP, {59'd0, state, trap_cause});
      prev_ireq = ibus_req;
      prev_dreq = dbus_req;
      prev_trap = trap;
    end
  end

  // One instruction: dwait<0 means dbus never acks; cause!=0 expects a trap.
  task automatic run_instr(input logic [31:0] word, input logic mem, input logic comp,
                           input int dwait, input logic [31:0] npc, input logic hreq,
                           input logic [1:0] cause);
    int n;
    if (mem) push(K_DBUS, 64'((dwait < 0) ? TO : dwait + 1));
    if (cause != 2'd0) push(K_TRAP, {59'd0, 3'd6, cause});
    else begin
      push(K_RET, ret_data(mem ? 5 + dwait : 4, exp_pc));
      if (!hreq) push(K_FETCH, {32'd0, npc});
    end
    n = 0;
    while (!ibus_req && n < 50) begin @(negedge clk); n++; end
    if (!ibus_req) begin
      checks++; errors++;
      $display("FAIL fetch_wait actual=no_req required=req");
      return;
    end
    ibus_rdata        = word;
    dec_is_mem_or_io  = mem;
    dec_is_compressed = comp;
    next_pc           = npc;
    halt_req          = hreq;
    ibus_ack          = 1'b1;
    @(negedge clk);
    ibus_ack = 1'b0;
    check("instr_reg", instruction, word);
    check("pc_step", pc_step, comp ? 3'd2 : 3'd4);
    if (mem) begin
      n = 0;
      while (!dbus_req && n < 50) begin @(negedge clk); n++; end
      if (!dbus_req) begin
        checks++; errors++;
        $display("FAIL dbus_wait actual=no_req required=req");
        return;
      end
      if (dwait >= 0) begin
        repeat (dwait) @(negedge clk);
        dbus_ack = 1'b1;
        @(negedge clk);
        dbus_ack = 1'b0;
      end
    end
    if (cause == 2'd0) exp_pc = npc;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain actual=%0d_pending required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic reset_and_release();
    rstn     = 1'b0;
    ibus_ack = 1'b0;
    ibus_err = 1'b0;
    dbus_ack = 1'b0;
    dbus_err = 1'b0;
    halt_req = 1'b0;
    dec_is_mem_or_io  = 1'b0;
    dec_is_compressed = 1'b0;
    repeat (2) @(negedge clk);
    exp_pc = 32'h0;
    push(K_FETCH, 64'h0);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int  n;
    logic ok;
    rstn = 1'b0;
    halt_req = 1'b0;
    ibus_ack = 1'b0; ibus_err = 1'b0; ibus_rdata = '0;
    dbus_ack = 1'b0; dbus_err = 1'b0;
    dec_is_mem_or_io = 1'b0; dec_is_compressed = 1'b0;
    next_pc = '0;
    exp_pc  = '0;
    repeat (2) @(negedge clk);

    // reset values
    check("rst_state", state, 3'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instruction, 32'h0000_0013);
    check("rst_trap", {trap, trap_cause}, 3'd0);
    check("rst_strobes", {ibus_req, dbus_req, exec_en, rf_we, retired}, 5'd0);
    check("rst_pc_step", pc_step, 3'd4);
    push(K_FETCH, 64'h0);
    rstn = 1'b1;
    @(negedge clk);
    check("req_after_release", ibus_req, 1'b1);

    // ADDI stream
    run_instr(32'h0010_0093, 1'b0, 1'b0, 0, 32'h4, 1'b0, 2'd0);
    run_instr(32'h0020_8113, 1'b0, 1'b0, 0, 32'h8, 1'b0, 2'd0);
    run_instr(32'h0031_0193, 1'b0, 1'b0, 0, 32'hC, 1'b0, 2'd0);
    // LW, ack on 4th dbus cycle (also the timeout-terminal cycle: ack wins)
    run_instr(32'h0000_A203, 1'b1, 1'b0, 3, 32'h10, 1'b0, 2'd0);
    // taken branch
    run_instr(32'h0E00_0063, 1'b0, 1'b0, 0, 32'h100, 1'b0, 2'd0);
    // halt after this one retires
    run_instr(32'h0000_0013, 1'b0, 1'b0, 0, 32'h104, 1'b1, 2'd0);
    n = 0;
    while (state != 3'd5 && n < 20) begin @(negedge clk); n++; end
    ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      ok &= (state == 3'd5) && !ibus_req && !retired && !rf_we;
    end
    check("halt_hold", ok, 1'b1);
    push(K_FETCH, {32'd0, 32'h104});
    halt_req = 1'b0;
    @(negedge clk);
    check("halt_release", {ibus_req, ibus_addr}, {1'b1, 32'h104});
    // PC wrap
    run_instr(32'h0000_0013, 1'b0, 1'b0, 0, 32'hFFFF_FFFC, 1'b0, 2'd0);
    run_instr(32'h0000_0013, 1'b0, 1'b0, 0, exp_pc + 32'd4, 1'b0, 2'd0);
    // fetch with ack and err together
    n = 0;
    while (!ibus_req && n < 50) begin @(negedge clk); n++; end
    push(K_TRAP, {59'd0, 3'd6, 2'd1});
    ibus_ack = 1'b1;
    ibus_err = 1'b1;
    @(negedge clk);
    ibus_ack = 1'b0;
    ibus_err = 1'b0;
    ok = 1'b1;
    repeat (4) begin
      @(negedge clk);
      ok &= (state == 3'd6) && trap && !rf_we && !retired && !ibus_req && !exec_en;
    end
    check("trap_hold", ok, 1'b1);
    check("trap_cause_err", trap_cause, 2'd1);
    drain();

    // reset asserted mid-fetch drops the request at once
    reset_and_release();
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("reset_drops_req", {ibus_req, state}, 4'd0);
    drain();

    // dbus timeout
    reset_and_release();
    run_instr(32'h0000_A203, 1'b1, 1'b0, -1, 32'h4, 1'b0, 2'd3);
    drain();
    check("trap_cause_to", {state, trap_cause}, {3'd6, 2'd3});

    // compressed instruction
    reset_and_release();
`ifdef RV32_SEQ_COMPRESSED_EN
    run_instr(32'h0000_0001, 1'b0, 1'b1, 0, 32'h2, 1'b0, 2'd0);
`else
    run_instr(32'h0000_0001, 1'b0, 1'b1, 0, 32'h2, 1'b0, 2'd2);
`endif
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
